// File: rtl/rx_delay_meter.sv
// rx_delay_meter: timestamps each RX frame at SOF and reports arrival minus embedded timestamp.
// Define RX_DELAY_MINMAX_EN to build the min/max delay trackers; otherwise min/max read 0.
module rx_delay_meter #(
    parameter int TS_OFFSET      = 14,
    parameter int STATUS_TIMEOUT = 16
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic [31:0] cur_time,
    input  logic        stats_clear,
    input  logic [7:0]  mac_rx_data,
    input  logic        mac_rx_dvld,
    input  logic        mac_rx_goodframe,
    input  logic        mac_rx_badframe,
    output logic        delay_valid,
    output logic [31:0] delay_value,
    output logic [31:0] frame_cnt,
    output logic [15:0] bad_cnt,
    output logic [15:0] short_cnt,
    output logic [31:0] min_delay,
    output logic [31:0] max_delay
);
    localparam int WCW = (STATUS_TIMEOUT > 1) ? $clog2(STATUS_TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, HDR, TS, PAYLOAD, WAIT_STAT, DROP} state_t;

    state_t          state;
    logic            dvld_q;
    logic [10:0]     byte_idx;
    logic [31:0]     sof_time;
    logic [31:0]     ts;
    logic [2:0]      ts_cnt;
    logic            stat_good;
    logic            stat_bad;
    logic [WCW-1:0]  wait_cnt;

    logic        sof, in_frame, in_bytes, any_good, any_bad, ts_take;
    logic        close, close_bad, measure, short_frm, bad_frm;
    logic [10:0] next_idx;
    logic [31:0] delay_new;

    assign sof       = mac_rx_dvld & ~dvld_q;
    assign in_bytes  = (state == HDR) || (state == TS) || (state == PAYLOAD);
    assign in_frame  = in_bytes || (state == WAIT_STAT);
    assign any_good  = stat_good | mac_rx_goodframe;
    assign any_bad   = stat_bad | mac_rx_badframe;
    // byte_idx holds the index of the last byte taken; next_idx is the byte on the bus now
    assign next_idx  = (byte_idx == 11'h7FF) ? byte_idx : byte_idx + 11'd1;
    assign ts_take   = ((state == HDR) && (next_idx == 11'(TS_OFFSET))) || (state == TS);
    assign delay_new = sof_time - ts;

    always_comb begin
        close     = 1'b0;
        close_bad = 1'b0;
        if (in_frame) begin
            if ((state == WAIT_STAT) && sof) begin
                close     = 1'b1;
                close_bad = 1'b1;
            end else if (!mac_rx_dvld && (any_good || any_bad)) begin
                close     = 1'b1;
                close_bad = any_bad;
            end else if ((state == WAIT_STAT) && (wait_cnt == WCW'(STATUS_TIMEOUT - 1))) begin
                close     = 1'b1;
                close_bad = 1'b1;
            end
        end
    end

    assign measure   = close && !close_bad && (ts_cnt == 3'd4);
    assign short_frm = close && !close_bad && (ts_cnt != 3'd4);
    assign bad_frm   = close && close_bad;

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            state     <= DROP;
            dvld_q    <= 1'b0;
            byte_idx  <= '0;
            sof_time  <= '0;
            ts        <= '0;
            ts_cnt    <= '0;
            stat_good <= 1'b0;
            stat_bad  <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            dvld_q <= mac_rx_dvld;
            if (state == DROP) begin
                if (!mac_rx_dvld)
                    state <= IDLE;
            end else begin
                if (in_frame) begin
                    stat_good <= any_good;
                    stat_bad  <= any_bad;
                end
                if (close)
                    state <= IDLE;
                if (in_bytes) begin
                    if (mac_rx_dvld) begin
                        byte_idx <= next_idx;
                        if (ts_take) begin
                            ts     <= {ts[23:0], mac_rx_data};
                            ts_cnt <= ts_cnt + 3'd1;
                            state  <= (ts_cnt == 3'd3) ? PAYLOAD : TS;
                        end
                    end else if (!close) begin
                        // the falling-edge cycle already counts as the first wait cycle
                        state    <= WAIT_STAT;
                        wait_cnt <= WCW'(1);
                    end
                end
                if ((state == WAIT_STAT) && !close)
                    wait_cnt <= wait_cnt + 1'b1;
                // a new SOF overrides the close of a pending frame in the same cycle
                if (sof && ((state == IDLE) || (state == WAIT_STAT))) begin
                    sof_time  <= cur_time;
                    byte_idx  <= '0;
                    stat_good <= 1'b0;
                    stat_bad  <= 1'b0;
                    wait_cnt  <= '0;
                    if (TS_OFFSET == 0) begin
                        ts     <= {24'd0, mac_rx_data};
                        ts_cnt <= 3'd1;
                        state  <= TS;
                    end else begin
                        ts_cnt <= '0;
                        state  <= HDR;
                    end
                end
            end
        end
    end

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            delay_valid <= 1'b0;
            delay_value <= '0;
        end else begin
            delay_valid <= measure;
            if (measure)
                delay_value <= delay_new;
        end
    end

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            bad_cnt   <= '0;
            short_cnt <= '0;
        end else if (stats_clear) begin
            frame_cnt <= '0;
            bad_cnt   <= '0;
            short_cnt <= '0;
        end else begin
            if (measure && (frame_cnt != '1))
                frame_cnt <= frame_cnt + 32'd1;
            if (bad_frm && (bad_cnt != '1))
                bad_cnt <= bad_cnt + 16'd1;
            if (short_frm && (short_cnt != '1))
                short_cnt <= short_cnt + 16'd1;
        end
    end

`ifdef RX_DELAY_MINMAX_EN
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            min_delay <= 32'hFFFF_FFFF;
            max_delay <= '0;
        end else if (stats_clear) begin
            min_delay <= 32'hFFFF_FFFF;
            max_delay <= '0;
        end else if (measure) begin
            if (delay_new < min_delay)
                min_delay <= delay_new;
            if (delay_new > max_delay)
                max_delay <= delay_new;
        end
    end
`else
    assign min_delay = '0;
    assign max_delay = '0;
`endif

endmodule
